// File: rtl/br_seq_pkg.sv
// Shared types and helpers for the buffer register sequencer.
// States, SENSE_CYCLES bounds, channel-enable decode and module-pair index.
package br_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_SENSE,
    ST_LOAD,
    ST_CHECK,
    ST_DONE
  } br_state_e;

  localparam int SENSE_CYCLES_MIN = 1;
  localparam int SENSE_CYCLES_MAX = 7;

  // Clamp the requested sense length into what the 3-bit counter can time.
  function automatic logic [2:0] sense_len(input int cycles);
    if (cycles < SENSE_CYCLES_MIN) return 3'(SENSE_CYCLES_MIN);
    if (cycles > SENSE_CYCLES_MAX) return 3'(SENSE_CYCLES_MAX);
    return 3'(cycles);
  endfunction

  // Returns {enable_b, enable_a}: even modules sit on A, odd modules on B.
  function automatic logic [1:0] channel_enables(input logic mod_lsb, input logic duplex);
    if (duplex) return 2'b11;
    return mod_lsb ? 2'b10 : 2'b01;
  endfunction

  // Even module of the pair that a duplex access uses.
  function automatic logic [2:0] pair_base(input logic [2:0] mod);
    return {mod[2:1], 1'b0};
  endfunction

endpackage

// File: rtl/br_sense_decode.sv
// Combinational decode of the captured module/duplex selection into
// per-module sense gating (only while sensing) and per-channel enables.
module br_sense_decode
  import br_seq_pkg::*;
(
  input  logic [2:0] mod,
  input  logic       duplex,
  input  br_state_e  state,
  output logic [7:0] msen,
  output logic       en_a,
  output logic       en_b
);

  logic [1:0] en;

  // Channel enables always reflect the selection; sense gating only in SENSE.
  always_comb begin
    en   = channel_enables(mod[0], duplex);
    en_a = en[0];
    en_b = en[1];
    msen = 8'h00;
    if (state == ST_SENSE) begin
      if (duplex) msen = 8'h03 << pair_base(mod);
      else        msen = 8'h01 << mod;
    end
  end

endmodule

// File: rtl/buffer_register_sequencer.sv
// Sequences one access through the duplex buffer register: clear, sense or
// load, parity check, done. Strobes are registered from the current state,
// so each strobe appears one cycle after its state is entered.
// Optional feature macro: BR_DUPLEX_COMPARE_EN (duplex A/B compare -> DISAGREE).
module buffer_register_sequencer
  import br_seq_pkg::*;
#(
  parameter int SENSE_CYCLES = 2
)(
  input  logic       CLK,
  input  logic       RESET,
  input  logic       V1,
  input  logic       REQ,
  input  logic       WR,
  input  logic [2:0] MOD,
  input  logic       DUPLEX,
  input  logic       PARA_OK,
  input  logic       PARB_OK,
  input  logic       BR_EQ,
  output logic       ACK,
  output logic       READY,
  output logic       DONE,
  output logic       A1CBRVN,
  output logic       A2CBRVN,
  output logic       A1SBRXV,
  output logic       A2SBRXV,
  output logic [7:0] MSEN,
  output logic       PERR_A,
  output logic       PERR_B,
  output logic       DISAGREE
);

  localparam logic [2:0] SENSE_LEN = sense_len(SENSE_CYCLES);

  br_state_e  state, next_state;
  logic [2:0] cnt, next_cnt;
  logic       accept;
  logic       wr_q, dup_q;
  logic [2:0] mod_q;
  logic       check_q;
  logic [7:0] msen_dec;
  logic       en_a, en_b;

  br_sense_decode u_decode (
    .mod    (mod_q),
    .duplex (dup_q),
    .state  (state),
    .msen   (msen_dec),
    .en_a   (en_a),
    .en_b   (en_b)
  );

  assign READY = V1 && (state == ST_IDLE);

  // Next-state and sense counter; a supply drop forces a return to idle.
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    accept     = 1'b0;
    if (!V1) begin
      next_state = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (REQ) begin
            accept     = 1'b1;
            next_state = ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          if (wr_q) begin
            next_state = ST_LOAD;
          end else begin
            next_state = ST_SENSE;
            next_cnt   = SENSE_LEN - 3'd1;
          end
        end
        ST_SENSE: begin
          if (cnt == 3'd0) next_state = ST_CHECK;
          else             next_cnt   = cnt - 3'd1;
        end
        ST_LOAD:  next_state = ST_DONE;
        ST_CHECK: next_state = ST_DONE;
        ST_DONE:  next_state = ST_IDLE;
        default:  next_state = ST_IDLE;
      endcase
    end
  end

  // State and sense counter registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= ST_IDLE;
      cnt   <= 3'd0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
    end
  end

  // Capture the access parameters at accept; they hold until the next accept.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wr_q  <= 1'b0;
      dup_q <= 1'b0;
      mod_q <= 3'd0;
    end else if (accept) begin
      wr_q  <= WR;
      dup_q <= DUPLEX;
      mod_q <= MOD;
    end
  end

  // Registered strobes decoded from the current state; all inactive when V1 is low.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ACK     <= 1'b0;
      DONE    <= 1'b0;
      A1CBRVN <= 1'b1;
      A2CBRVN <= 1'b1;
      A1SBRXV <= 1'b0;
      A2SBRXV <= 1'b0;
      MSEN    <= 8'h00;
      check_q <= 1'b0;
    end else if (!V1) begin
      ACK     <= 1'b0;
      DONE    <= 1'b0;
      A1CBRVN <= 1'b1;
      A2CBRVN <= 1'b1;
      A1SBRXV <= 1'b0;
      A2SBRXV <= 1'b0;
      MSEN    <= 8'h00;
      check_q <= 1'b0;
    end else begin
      ACK     <= accept;
      DONE    <= (state == ST_DONE);
      A1CBRVN <= !((state == ST_CLEAR) && en_a);
      A2CBRVN <= !((state == ST_CLEAR) && en_b);
      A1SBRXV <= (state == ST_LOAD) && en_a;
      A2SBRXV <= (state == ST_LOAD) && en_b;
      MSEN    <= msen_dec;
      check_q <= (state == ST_CHECK);
    end
  end

  // Sticky parity errors: cleared at accept, set by a failed check on an enabled channel.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      PERR_A <= 1'b0;
      PERR_B <= 1'b0;
    end else if (accept) begin
      PERR_A <= 1'b0;
      PERR_B <= 1'b0;
    end else if (V1 && check_q) begin
      if (en_a && !PARA_OK) PERR_A <= 1'b1;
      if (en_b && !PARB_OK) PERR_B <= 1'b1;
    end
  end

`ifdef BR_DUPLEX_COMPARE_EN
  // Sticky duplex miscompare, sampled alongside parity on duplex reads.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      DISAGREE <= 1'b0;
    end else if (accept) begin
      DISAGREE <= 1'b0;
    end else if (V1 && check_q && dup_q && !BR_EQ) begin
      DISAGREE <= 1'b1;
    end
  end
`else
  logic unused_br_eq;
  assign unused_br_eq = BR_EQ;
  assign DISAGREE     = 1'b0;
`endif

endmodule

// File: tb/tb_buffer_register_sequencer.sv
// Self-checking bench for buffer_register_sequencer: each access pushes its
// expected timeline to a scoreboard, which is popped and compared at DONE.
module tb_buffer_register_sequencer;

  localparam int SC = 2;

  logic       CLK = 1'b0;
  logic       RESET, V1, REQ, WR, DUPLEX, PARA_OK, PARB_OK, BR_EQ;
  logic [2:0] MOD;
  logic       ACK, READY, DONE, A1CBRVN, A2CBRVN, A1SBRXV, A2SBRXV;
  logic       PERR_A, PERR_B, DISAGREE;
  logic [7:0] MSEN;

  int checks = 0;
  int errors = 0;

  // Strobe fields encode first_cycle*16 + active_cycle_count (0 = never).
  typedef struct packed {
    int clr_a;
    int clr_b;
    int ld_a;
    int ld_b;
    int msen_first;
    int msen_cnt;
    int msen_val;
    int done_cyc;
    int perr_a;
    int perr_b;
    int disagree;
  } exp_t;

  exp_t sb[$];

  buffer_register_sequencer #(.SENSE_CYCLES(SC)) dut (
    .CLK(CLK), .RESET(RESET), .V1(V1), .REQ(REQ), .WR(WR), .MOD(MOD),
    .DUPLEX(DUPLEX), .PARA_OK(PARA_OK), .PARB_OK(PARB_OK), .BR_EQ(BR_EQ),
    .ACK(ACK), .READY(READY), .DONE(DONE), .A1CBRVN(A1CBRVN), .A2CBRVN(A2CBRVN),
    .A1SBRXV(A1SBRXV), .A2SBRXV(A2SBRXV), .MSEN(MSEN), .PERR_A(PERR_A),
    .PERR_B(PERR_B), .DISAGREE(DISAGREE)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, actual, actual, expected, expected);
    end
  endtask

  function automatic exp_t model(input bit wr, input bit [2:0] mod, input bit dup,
                                 input bit para, input bit parb, input bit beq);
    exp_t e;
    bit ea, eb;
    e  = '0;
    ea = dup || !mod[0];
    eb = dup || mod[0];
    e.clr_a = ea ? 17 : 0;
    e.clr_b = eb ? 17 : 0;
    if (wr) begin
      e.ld_a     = ea ? 33 : 0;
      e.ld_b     = eb ? 33 : 0;
      e.done_cyc = 3;
    end else begin
      e.msen_first = 2;
      e.msen_cnt   = SC;
      e.msen_val   = dup ? (3 << {mod[2:1], 1'b0}) : (1 << mod);
      e.done_cyc   = SC + 3;
      e.perr_a     = (ea && !para) ? 1 : 0;
      e.perr_b     = (eb && !parb) ? 1 : 0;
`ifdef BR_DUPLEX_COMPARE_EN
      e.disagree   = (dup && !beq) ? 1 : 0;
`else
      e.disagree   = (beq && !beq) ? 1 : 0;
`endif
    end
    return e;
  endfunction

  // Drive a request and wait (bounded) for ACK; leaves the bench at cycle 0.
  task automatic requestAccess(input bit wr, input bit [2:0] mod, input bit dup,
                               input bit para, input bit parb, input bit beq,
                               output bit got_ack);
    @(negedge CLK);
    REQ = 1'b1; WR = wr; MOD = mod; DUPLEX = dup;
    PARA_OK = para; PARB_OK = parb; BR_EQ = beq;
    got_ack = 1'b0;
    for (int i = 0; i < 20 && !got_ack; i++) begin
      @(negedge CLK);
      if (ACK) got_ack = 1'b1;
    end
    REQ = 1'b0;
  endtask

  task automatic applyStimulus(input bit wr, input bit [2:0] mod, input bit dup,
                               input bit para, input bit parb, input bit beq);
    exp_t e, o;
    bit   got_ack;
    int   viol, nact;
    sb.push_back(model(wr, mod, dup, para, parb, beq));
    requestAccess(wr, mod, dup, para, parb, beq, got_ack);
    checkOutput("ack_seen", int'(got_ack), 1);
    checkOutput("flags_clear_at_ack", int'({PERR_A, PERR_B, DISAGREE}), 0);
    o    = '0;
    viol = 0;
    for (int c = 1; c <= 15; c++) begin
      @(negedge CLK);
      if (!A1CBRVN) begin if (o.clr_a == 0) o.clr_a = c * 16; o.clr_a = o.clr_a + 1; end
      if (!A2CBRVN) begin if (o.clr_b == 0) o.clr_b = c * 16; o.clr_b = o.clr_b + 1; end
      if (A1SBRXV)  begin if (o.ld_a == 0)  o.ld_a  = c * 16; o.ld_a  = o.ld_a + 1;  end
      if (A2SBRXV)  begin if (o.ld_b == 0)  o.ld_b  = c * 16; o.ld_b  = o.ld_b + 1;  end
      if (MSEN != 8'h00) begin
        if (o.msen_first == 0) begin
          o.msen_first = c;
          o.msen_val   = int'(MSEN);
        end
        o.msen_cnt = o.msen_cnt + 1;
      end
      nact = 0;
      if (!A1CBRVN || !A2CBRVN)  nact++;
      if (A1SBRXV || A2SBRXV)    nact++;
      if (MSEN != 8'h00)         nact++;
      if (nact > 1) viol++;
      if (DONE) begin
        o.done_cyc = c;
        o.perr_a   = int'(PERR_A);
        o.perr_b   = int'(PERR_B);
        o.disagree = int'(DISAGREE);
        break;
      end
    end
    e = sb.pop_front();
    checkOutput("clear_a", o.clr_a, e.clr_a);
    checkOutput("clear_b", o.clr_b, e.clr_b);
    checkOutput("load_a", o.ld_a, e.ld_a);
    checkOutput("load_b", o.ld_b, e.ld_b);
    checkOutput("msen_first", o.msen_first, e.msen_first);
    checkOutput("msen_cycles", o.msen_cnt, e.msen_cnt);
    checkOutput("msen_value", o.msen_val, e.msen_val);
    checkOutput("done_cycle", o.done_cyc, e.done_cyc);
    checkOutput("perr_a", o.perr_a, e.perr_a);
    checkOutput("perr_b", o.perr_b, e.perr_b);
    checkOutput("disagree", o.disagree, e.disagree);
    checkOutput("strobe_overlap", viol, 0);
  endtask

  initial begin
    bit got_ack;
    int dones;
    RESET = 1'b1; V1 = 1'b0; REQ = 1'b0; WR = 1'b0; MOD = 3'd0; DUPLEX = 1'b0;
    PARA_OK = 1'b1; PARB_OK = 1'b1; BR_EQ = 1'b1;
    $display("[TB] reset checks");
    repeat (3) @(negedge CLK);
    checkOutput("rst_a1cbrvn", int'(A1CBRVN), 1);
    checkOutput("rst_a2cbrvn", int'(A2CBRVN), 1);
    checkOutput("rst_sbrxv", int'({A1SBRXV, A2SBRXV}), 0);
    checkOutput("rst_msen", int'(MSEN), 0);
    checkOutput("rst_ack_done", int'({ACK, DONE}), 0);
    checkOutput("rst_flags", int'({PERR_A, PERR_B, DISAGREE}), 0);
    checkOutput("rst_ready_v1_low", int'(READY), 0);
    RESET = 1'b0;
    V1    = 1'b1;
    @(negedge CLK);
    checkOutput("ready_idle", int'(READY), 1);

    $display("[TB] simplex read MOD=3");
    applyStimulus(1'b0, 3'd3, 1'b0, 1'b1, 1'b1, 1'b1);
    $display("[TB] duplex read MOD=4 with channel A parity error");
    applyStimulus(1'b0, 3'd4, 1'b1, 1'b0, 1'b1, 1'b1);
    $display("[TB] duplex write MOD=0");
    applyStimulus(1'b1, 3'd0, 1'b1, 1'b1, 1'b1, 1'b1);

    $display("[TB] abort during sense");
    requestAccess(1'b0, 3'd1, 1'b0, 1'b1, 1'b1, 1'b1, got_ack);
    checkOutput("abort_ack", int'(got_ack), 1);
    @(negedge CLK);
    @(negedge CLK);
    checkOutput("abort_msen_before", int'(MSEN), 8'h02);
    V1 = 1'b0;
    @(negedge CLK);
    checkOutput("abort_msen_after", int'(MSEN), 0);
    checkOutput("abort_ready", int'(READY), 0);
    dones = int'(DONE);
    repeat (6) begin
      @(negedge CLK);
      if (DONE) dones++;
    end
    checkOutput("abort_no_done", dones, 0);
    V1 = 1'b1;
    @(negedge CLK);
    checkOutput("abort_ready_back", int'(READY), 1);
    applyStimulus(1'b0, 3'd5, 1'b0, 1'b1, 1'b0, 1'b1);

    $display("[TB] sticky flags through V1 low");
    V1 = 1'b0;
    repeat (2) @(negedge CLK);
    checkOutput("sticky_perr_b", int'(PERR_B), 1);
    checkOutput("sticky_ready", int'(READY), 0);
    V1 = 1'b1;

    $display("[TB] duplex read with BR_EQ low");
    applyStimulus(1'b0, 3'd6, 1'b1, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 3'd2, 1'b0, 1'b1, 1'b1, 1'b1);

    $display("[TB] reset during clear");
    requestAccess(1'b1, 3'd2, 1'b0, 1'b1, 1'b1, 1'b1, got_ack);
    checkOutput("midrst_ack", int'(got_ack), 1);
    @(negedge CLK);
    checkOutput("midrst_clear_low", int'(A1CBRVN), 0);
    #1 RESET = 1'b1;
    #1;
    checkOutput("midrst_async_a1cbrvn", int'(A1CBRVN), 1);
    checkOutput("midrst_async_sbrxv", int'({A1SBRXV, A2SBRXV}), 0);
    @(negedge CLK);
    RESET = 1'b0;
    repeat (3) @(negedge CLK);
    checkOutput("midrst_no_load", int'({A1SBRXV, A2SBRXV, DONE}), 0);
    checkOutput("midrst_ready", int'(READY), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
